// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the interval-timer controller: default widths and FSM state encodings.
package counter_ctrl_pkg;

    localparam int unsigned DefCntW = 4;
    localparam int unsigned DefPreW = 3;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler counter with enable and clear.
// at_term is high while the count sits on term_val, which is the cycle a tick is due.
module counter_prescaler
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned PRE_W = DefPreW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [PRE_W-1:0] term_val,
    output logic             at_term
);

    logic [PRE_W-1:0] cnt_q;

    // Unqualified by en so the controller can use it to decide en without a loop.
    assign at_term = (cnt_q == term_val);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_term ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Interval-timer controller: latches configuration, sequences the prescaler and main counter,
// and emits registered tick/done pulses.
module counter_seq_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned PRE_W = DefPreW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic [PRE_W-1:0] cfg_prescale,
    input  logic             cfg_reload,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] limit_q;
    logic [PRE_W-1:0] prescale_q;
    logic             reload_q;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             pre_en, pre_clr, pre_term;
    logic             advance;
    logic             cfg_fire;

    assign busy      = (state_q == StRun) || (state_q == StPause);
    assign cfg_ready = !busy;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign state     = state_q;
    assign count     = count_q;
    assign tick      = tick_q;
    assign done      = done_q;

    // A terminal event in RUN wins over a simultaneous pause; releasing pause counts that cycle.
    assign advance = busy && (!pause || (state_q == StRun && pre_term));

    counter_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (pre_en),
        .clr      (pre_clr),
        .term_val (prescale_q),
        .at_term  (pre_term)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        pre_en  = 1'b0;
        pre_clr = 1'b0;
        if (stop) begin
            state_d = StIdle;
            count_d = '0;
            pre_clr = 1'b1;
        end else if (start) begin
            state_d = StRun;
            count_d = '0;
            pre_clr = 1'b1;
        end else if (busy) begin
            if (advance) begin
                state_d = StRun;
                pre_en  = 1'b1;
                if (pre_term) begin
                    tick_d = 1'b1;
                    if (count_q == limit_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            count_d = '0;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end else begin
                state_d = StPause;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            limit_q    <= '1;
            prescale_q <= '0;
            reload_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            if (cfg_fire) begin
                limit_q    <= cfg_limit;
                prescale_q <= cfg_prescale;
                reload_q   <= cfg_reload;
            end
        end
    end

endmodule
